// File: rtl/player_motion_ctrl_if.sv
// Signal bundle between the game logic (master) and player_motion_ctrl (slave):
// controls and collision results in, position and status out.
interface player_motion_ctrl_if;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic       restart;
  logic       on_ground;
  logic [9:0] support_y;
  logic       hit_ceiling;
  logic       hit_left_wall;
  logic       hit_right_wall;
  logic       at_goal_region;
  logic       in_lava;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       dead;
  logic       won;
  logic       frame_done;
  logic       overrun;

  modport master (
    output frame_tick, btn_left, btn_right, btn_jump, restart,
    output on_ground, support_y, hit_ceiling, hit_left_wall, hit_right_wall,
    output at_goal_region, in_lava,
    input  player_x, player_y, dead, won, frame_done, overrun
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_jump, restart,
    input  on_ground, support_y, hit_ceiling, hit_left_wall, hit_right_wall,
    input  at_goal_region, in_lava,
    output player_x, player_y, dead, won, frame_done, overrun
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion: horizontal step, gravity/jump velocity, then pixel-by-pixel
// vertical movement so collision results can be re-sampled after every position change.
module player_motion_ctrl #(
  parameter logic [9:0] START_X  = 10'd20,
  parameter logic [9:0] START_Y  = 10'd344,
  parameter logic [9:0] H_SPEED  = 10'd2,
  parameter logic [4:0] JUMP_VEL = 5'd8,
  parameter logic [4:0] GRAVITY  = 5'd1,
  parameter logic [4:0] MAX_FALL = 5'd6
) (
  input logic                 clk,
  input logic                 rst_n,
  player_motion_ctrl_if.slave bus
);

  localparam logic [9:0]        X_MAX      = 10'd624;
  localparam logic [9:0]        Y_MAX      = 10'd463;
  localparam logic [9:0]        PLAYER_H   = 10'd16;
  localparam logic signed [6:0] MAX_FALL_S = {2'b00, MAX_FALL};
  localparam logic signed [6:0] GRAVITY_S  = {2'b00, GRAVITY};

  typedef enum logic [2:0] {
    IDLE, HMOVE, VINIT, VSTEP, CHECK, DEAD, WON
  } state_e;

  state_e            state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic signed [5:0] vy_q, vy_d;
  logic [4:0]        step_q, step_d;
  logic              left_q, left_d;
  logic              right_q, right_d;
  logic              jump_q, jump_d;
  logic              dead_q, dead_d;
  logic              won_q, won_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic [10:0]       x_plus;
  logic signed [6:0] vy_grav;
  logic signed [6:0] vy_fall;
  logic signed [6:0] vy_mag;
  logic              grounded;
  logic              busy;

  always_comb begin
    // NOTE: every _d and helper gets a default first, so no path through the case can infer a latch.
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    vy_d      = vy_q;
    step_d    = step_q;
    left_d    = left_q;
    right_d   = right_q;
    jump_d    = jump_q;
    dead_d    = dead_q;
    won_d     = won_q;
    overrun_d = overrun_q;
    done_d    = 1'b0;

    x_plus   = {1'b0, x_q} + {1'b0, H_SPEED};
    vy_grav  = $signed({vy_q[5], vy_q}) + GRAVITY_S;
    vy_fall  = (vy_grav > MAX_FALL_S) ? MAX_FALL_S : vy_grav;
    vy_mag   = vy_fall[6] ? -vy_fall : vy_fall;
    grounded = bus.on_ground && !vy_q[5];
    busy     = (state_q == HMOVE) || (state_q == VINIT) ||
               (state_q == VSTEP) || (state_q == CHECK);

    case (state_q)
      IDLE: begin
        if (bus.frame_tick) begin
          left_d  = bus.btn_left;
          right_d = bus.btn_right;
          jump_d  = bus.btn_jump;
          state_d = HMOVE;
        end
      end

      HMOVE: begin
        if (left_q && !right_q && !bus.hit_left_wall) begin
          x_d = (x_q >= H_SPEED) ? x_q - H_SPEED : 10'd0;
        end else if (right_q && !left_q && !bus.hit_right_wall) begin
          x_d = (x_plus > {1'b0, X_MAX}) ? X_MAX : x_plus[9:0];
        end
        state_d = VINIT;
      end

      VINIT: begin
        if (grounded && jump_q) begin
          vy_d    = -$signed({1'b0, JUMP_VEL});
          step_d  = JUMP_VEL;
          state_d = VSTEP;
        end else if (grounded) begin
          vy_d    = '0;
          y_d     = (bus.support_y >= PLAYER_H) ? bus.support_y - PLAYER_H : 10'd0;
          state_d = CHECK;
        end else begin
          vy_d    = vy_fall[5:0];
          step_d  = vy_mag[4:0];
          state_d = (vy_mag == 7'sd0) ? CHECK : VSTEP;
        end
      end

      // The final pixel move goes straight to CHECK; CHECK is the cycle that samples
      // the collision results for that last position.
      VSTEP: begin
        if (step_q == 5'd0) begin
          state_d = CHECK;
        end else if (!vy_q[5]) begin
          if (bus.on_ground) begin
            vy_d    = '0;
            state_d = CHECK;
          end else if (y_q >= Y_MAX) begin
            state_d = CHECK;
          end else begin
            y_d    = y_q + 10'd1;
            step_d = step_q - 5'd1;
            if (step_q == 5'd1) state_d = CHECK;
          end
        end else begin
          if (bus.hit_ceiling || (y_q == 10'd0)) begin
            vy_d    = '0;
            state_d = CHECK;
          end else begin
            y_d    = y_q - 10'd1;
            step_d = step_q - 5'd1;
            if (step_q == 5'd1) state_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (bus.in_lava) begin
          dead_d  = 1'b1;
          state_d = DEAD;
        end else if (bus.at_goal_region && bus.on_ground) begin
          won_d   = 1'b1;
          state_d = WON;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      DEAD, WON: ;

      default: state_d = IDLE;
    endcase

    // Only a tick landing mid-update is an overrun; DEAD/WON simply ignore ticks.
    if (bus.frame_tick && busy) overrun_d = 1'b1;

    if (bus.restart) begin
      state_d = IDLE;
      x_d     = START_X;
      y_d     = START_Y;
      vy_d    = '0;
      step_d  = '0;
      left_d  = 1'b0;
      right_d = 1'b0;
      jump_d  = 1'b0;
      dead_d  = 1'b0;
      won_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= START_X;
      y_q       <= START_Y;
      vy_q      <= '0;
      step_q    <= '0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      jump_q    <= 1'b0;
      dead_q    <= 1'b0;
      won_q     <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vy_q      <= vy_d;
      step_q    <= step_d;
      left_q    <= left_d;
      right_q   <= right_d;
      jump_q    <= jump_d;
      dead_q    <= dead_d;
      won_q     <= won_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.player_x   = x_q;
  assign bus.player_y   = y_q;
  assign bus.dead       = dead_q;
  assign bus.won        = won_q;
  assign bus.frame_done = done_q;
  assign bus.overrun    = overrun_q;

endmodule
